// File: rtl/temporal_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : temporal_decoder
//  Description : Multi-lane unary/temporal-to-binary decoder. A start pulse
//                opens a window of W = 2^BIT_WIDTH - 1 samples. Each lane
//                counts its '1' samples over the window. The counts are then
//                held on 'out' with a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module temporal_decoder #(
    parameter int BIT_WIDTH = 8,
    parameter int LANES     = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [LANES-1:0]                stream_in,
    input  logic                            out_ready,
    output logic [LANES-1:0][BIT_WIDTH-1:0] out,
    output logic                            out_valid,
    output logic                            busy
);

    // The cycle counter reads W-1 while the final sample of the window is taken.
    // W-1 = 2^BIT_WIDTH - 2 is written as all ones with the LSB cleared.
    // BIT_WIDTH must be at least 2 so that the window has more than one sample.
    localparam logic [BIT_WIDTH-1:0] c_LAST_SAMPLE = {{(BIT_WIDTH-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                            r_state;
    state_t                            w_state_nxt;
    logic [BIT_WIDTH-1:0]              r_cyc_cnt;
    logic [LANES-1:0][BIT_WIDTH-1:0]   r_lane_cnt;
    logic [LANES-1:0][BIT_WIDTH-1:0]   w_lane_sum;
    logic [LANES-1:0][BIT_WIDTH-1:0]   r_out;
    logic                              w_accept;
    logic                              w_last;

    // A new window opens from IDLE, or from HOLD when the result is retired in the same cycle.
    assign w_accept = start && ((r_state == S_IDLE) ||
                                ((r_state == S_HOLD) && out_ready));

    // The final sample of the window is being taken this cycle.
    assign w_last   = (r_state == S_COUNT) && (r_cyc_cnt == c_LAST_SAMPLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_COUNT;
                end
            end
            S_COUNT: begin
                if (w_last) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = start ? S_COUNT : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Per-lane running sum including the current sample.
    // A lane sees at most W ones, so the sum never exceeds BIT_WIDTH bits.
    always_comb begin
        w_lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_lane_sum[i] = r_lane_cnt[i] + BIT_WIDTH'(stream_in[i]);
        end
    end

    // Sample counter: 1 after the accept cycle, W after the final sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cyc_cnt <= '0;
        end else if (w_accept) begin
            r_cyc_cnt <= BIT_WIDTH'(1);
        end else if (r_state == S_COUNT) begin
            r_cyc_cnt <= r_cyc_cnt + BIT_WIDTH'(1);
        end
    end

    // Lane counters. The accept cycle is sample 0, so it loads directly and discards any prior count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lane_cnt <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < LANES; i++) begin
                r_lane_cnt[i] <= {{(BIT_WIDTH-1){1'b0}}, stream_in[i]};
            end
        end else if (r_state == S_COUNT) begin
            r_lane_cnt <= w_lane_sum;
        end
    end

    // Result register. It is loaded only on entry to HOLD, with the final sample included.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= '0;
        end else if (w_last) begin
            r_out <= w_lane_sum;
        end
    end

    assign out       = r_out;
    assign out_valid = (r_state == S_HOLD);
    assign busy      = (r_state == S_COUNT);

endmodule
`default_nettype wire

// File: tb/tb_temporal_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_temporal_decoder
//  Description : Self-checking bench for temporal_decoder. Windows are built as
//                arrays of lane vectors. Expected counts are plain per-lane sums
//                over the W samples of each window.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_temporal_decoder;

    localparam int BW    = 8;
    localparam int LN    = 16;
    localparam int W     = (1 << BW) - 1;
    localparam int OUTW  = LN * BW;

    logic                   clk;
    logic                   reset;
    logic                   start;
    logic [LN-1:0]          stream_in;
    logic                   out_ready;
    logic [LN-1:0][BW-1:0]  out;
    logic                   out_valid;
    logic                   busy;

    int checks;
    int errors;

    logic [LN-1:0]          vec [W];
    logic [LN-1:0][BW-1:0]  prev_out;
    logic [LN-1:0][BW-1:0]  exp_out;

    temporal_decoder #(
        .BIT_WIDTH (BW),
        .LANES     (LN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stream_in (stream_in),
        .out_ready (out_ready),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [OUTW-1:0] obs, input logic [OUTW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the current inputs at one rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Build one window of samples.
    // Mode 0: all ones. Mode 1: mixed-lane pattern. Otherwise: random.
    task automatic build_window(input int mode);
        for (int i = 0; i < W; i++) begin
            case (mode)
                0: vec[i] = '1;
                1: begin
                    vec[i]    = LN'($urandom);
                    vec[i][0] = 1'b0;
                    vec[i][1] = (i % 2 == 0);
                    vec[i][2] = (i < 100);
                end
                default: vec[i] = LN'($urandom);
            endcase
        end
        for (int l = 0; l < LN; l++) begin
            int s;
            s = 0;
            for (int i = 0; i < W; i++) s += int'(vec[i][l]);
            exp_out[l] = BW'(s);
        end
    endtask

    // Run one window. Sample 0 is taken at the first edge.
    // On return the DUT is in HOLD with the result presented.
    // If inject10 is set, an extra start is pulsed at sample 10.
    task automatic run_window(input string tag, input bit inject10);
        chk({tag, "_busy_at_accept"}, OUTW'(busy), OUTW'(0));
        for (int i = 0; i < W; i++) begin
            if (i == 0) start = 1'b1;
            else if (inject10) start = (i == 10);
            else start = ($urandom_range(0, 7) == 0);
            if (i != 0) out_ready = 1'($urandom);
            stream_in = vec[i];
            tick();
            if (i < W - 1) begin
                chk({tag, "_busy"},  OUTW'(busy),      OUTW'(1));
                chk({tag, "_valid"}, OUTW'(out_valid), OUTW'(0));
            end
            if (i == W / 2) chk({tag, "_out_stable"}, out, prev_out);
        end
        start     = 1'b0;
        out_ready = 1'b0;
        chk({tag, "_valid_end"}, OUTW'(out_valid), OUTW'(1));
        chk({tag, "_busy_end"},  OUTW'(busy),      OUTW'(0));
        chk({tag, "_counts"},    out,              exp_out);
        prev_out = exp_out;
    endtask

    // Retire the held result and return to IDLE.
    task automatic retire(input string tag);
        out_ready = 1'b1;
        start     = 1'b0;
        stream_in = LN'($urandom);
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, OUTW'(out_valid), OUTW'(0));
        chk({tag, "_idle_busy"},  OUTW'(busy),      OUTW'(0));
        chk({tag, "_out_kept"},   out,              prev_out);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        prev_out  = '0;
        exp_out   = '0;
        reset     = 1'b1;
        start     = 1'b1;
        stream_in = '1;
        out_ready = 1'b0;

        // Reset with a coincident start.
        tick();
        tick();
        chk("rst_valid", OUTW'(out_valid), OUTW'(0));
        chk("rst_busy",  OUTW'(busy),      OUTW'(0));
        chk("rst_out",   out,              OUTW'(0));
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("post_rst_busy", OUTW'(busy), OUTW'(0));

        // Idle: stream_in and out_ready are ignored.
        for (int i = 0; i < 5; i++) begin
            stream_in = LN'($urandom);
            out_ready = 1'($urandom);
            tick();
            chk("idle_busy",  OUTW'(busy),      OUTW'(0));
            chk("idle_valid", OUTW'(out_valid), OUTW'(0));
        end
        out_ready = 1'b0;

        // Full window of ones.
        build_window(0);
        run_window("full", 1'b0);
        retire("full");

        // Mixed lanes.
        build_window(1);
        run_window("mixed", 1'b0);
        chk("mixed_lane0", OUTW'(out[0]), OUTW'(0));
        chk("mixed_lane1", OUTW'(out[1]), OUTW'(128));
        chk("mixed_lane2", OUTW'(out[2]), OUTW'(100));

        // Backpressure while start and stream_in toggle in HOLD.
        for (int i = 0; i < 20; i++) begin
            out_ready = 1'b0;
            start     = 1'($urandom);
            stream_in = LN'($urandom);
            tick();
            chk("bp_valid", OUTW'(out_valid), OUTW'(1));
            chk("bp_busy",  OUTW'(busy),      OUTW'(0));
            chk("bp_out",   out,              prev_out);
        end
        retire("bp");
        for (int i = 0; i < 4; i++) begin
            stream_in = LN'($urandom);
            tick();
            chk("bp_no_new_window", OUTW'(busy), OUTW'(0));
        end

        // Back-to-back windows. Retire and accept in the same HOLD cycle.
        build_window(2);
        run_window("b2b_a", 1'b0);
        build_window(2);
        out_ready = 1'b1;
        run_window("b2b_b", 1'b0);
        retire("b2b");

        // Reset at sample 50, with a coincident start.
        build_window(2);
        for (int i = 0; i <= 50; i++) begin
            start     = (i == 0) || (i == 50);
            reset     = (i == 50);
            stream_in = vec[i];
            tick();
        end
        reset = 1'b0;
        start = 1'b0;
        chk("rstmid_valid", OUTW'(out_valid), OUTW'(0));
        chk("rstmid_busy",  OUTW'(busy),      OUTW'(0));
        chk("rstmid_out",   out,              OUTW'(0));
        prev_out = '0;
        for (int i = 0; i < W + 5; i++) begin
            stream_in = LN'($urandom);
            tick();
            chk("rstmid_no_valid", OUTW'(out_valid), OUTW'(0));
        end
        build_window(2);
        run_window("fresh", 1'b0);

        // Reset while holding a result.
        reset     = 1'b1;
        out_ready = 1'b0;
        tick();
        reset = 1'b0;
        chk("rsthold_valid", OUTW'(out_valid), OUTW'(0));
        chk("rsthold_out",   out,              OUTW'(0));
        prev_out = '0;
        tick();
        chk("rsthold_idle", OUTW'(out_valid), OUTW'(0));

        // A start pulse during COUNT is ignored. The window still ends after W samples.
        build_window(2);
        run_window("start_in_count", 1'b1);
        retire("start_in_count");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/temporal_decoder.md
TEMPORAL_DECODER -- requirements
Module: temporal_decoder

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8: output count width; window length W = 2^BIT_WIDTH - 1 cycles.
REQ-002 SHALL have parameter LANES, default 16: number of independent unary input lanes.
REQ-003 SHALL provide port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL provide port start, input, 1: requests a new counting window.
REQ-006 SHALL provide port stream_in, input, [LANES-1:0]: one temporal/unary bit per lane per cycle.
REQ-007 SHALL provide port out_ready, input, 1: consumer accepts the presented result.
REQ-008 SHALL provide port out, output, [LANES-1:0][BIT_WIDTH-1:0]: per-lane decoded binary counts.
REQ-009 SHALL provide port out_valid, output, 1: out holds a completed result.
REQ-010 SHALL provide port busy, output, 1: a window is being counted.

Function
REQ-011 SHALL implement three states: IDLE, COUNT, HOLD.
REQ-012 In IDLE, start=1 SHALL be accepted; the start cycle is sample 0; next state COUNT.
REQ-013 On acceptance, each lane counter SHALL load stream_in[i] (0 or 1), discarding any prior count; the cycle counter SHALL load 1.
REQ-014 In COUNT, each cycle SHALL add stream_in[i] to lane counter i; the cycle counter SHALL increment by 1.
REQ-015 When the cycle counter equals W-1 in COUNT, that cycle SHALL be the last sample (W samples total); next state HOLD.
REQ-016 On entry to HOLD, out SHALL be registered from the final lane counts and out_valid SHALL assert; latency: start sampled at cycle T gives out_valid=1 at cycle T+W.
REQ-017 Lane counts SHALL never exceed W, so they SHALL fit in BIT_WIDTH bits with no saturation or wrap logic required.
REQ-018 In HOLD, out and out_valid SHALL remain stable until out_ready=1.
REQ-019 In HOLD with out_ready=1 and start=0, the state SHALL go to IDLE and out_valid SHALL deassert the next cycle.
REQ-020 In HOLD with out_ready=1 and start=1 in the same cycle, the result SHALL be retired and a new window SHALL be accepted with that cycle as sample 0 (next state COUNT).
REQ-021 start SHALL be ignored in COUNT, and in HOLD when out_ready=0.
REQ-022 stream_in SHALL be ignored in IDLE, and in HOLD unless a new window is accepted per REQ-020.
REQ-023 out_ready SHALL be ignored outside HOLD.
REQ-024 busy SHALL be 1 exactly in COUNT, and during the accepting cycle it SHALL be 0 (it is registered from state).
REQ-025 out SHALL change only on entry to HOLD.

Reset
REQ-026 reset=1 SHALL force state IDLE, out_valid=0, busy=0, out=0, and all lane and cycle counters to 0 at the next clock edge, regardless of state.
REQ-027 reset asserted mid-COUNT or in HOLD SHALL discard the partial or pending result; no out_valid pulse SHALL follow.
REQ-028 start coincident with reset SHALL be ignored.

Verification
REQ-029 SHALL check full window: BIT_WIDTH=8, start with all lanes stream_in=1 for 255 cycles, out_ready=1 -> out_valid exactly 255 cycles after start, every lane = 255, out_valid drops the next cycle.
REQ-030 SHALL check mixed lanes: lane0 all 0, lane1 alternating 1/0 beginning at 1, lane2 first 100 samples 1 then 0 -> lane0 = 0, lane1 = 128, lane2 = 100.
REQ-031 SHALL check backpressure and ignored start: out_ready=0 for 20 cycles in HOLD while start pulses, stream_in changes, and out stays constant with out_valid=1; then out_ready=1 -> IDLE, with no new window started.
REQ-032 SHALL check back-to-back: out_ready=1 with start=1 in the same HOLD cycle -> the next result is valid W cycles later with correct counts, including sample 0 from the accept cycle.
REQ-033 SHALL check reset mid-COUNT: reset at sample 50 -> all outputs 0 next cycle, no out_valid; a fresh start then yields correct counts.
REQ-034 SHALL check start during COUNT: start pulse at sample 10 -> ignored; the window still ends at T+W.
